// File: rtl/mcontr_pkg.sv
// Shared constants, state encoding and helpers for the SDRAM controller access path.
package mcontr_pkg;

  localparam int NUM_CHN  = 9;
  localparam int REFR_CHN = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acc_state_e;

  // Isolates the lowest set bit: v & (two's complement of v).
  function automatic logic [NUM_CHN-1:0] lowest_onehot(input logic [NUM_CHN-1:0] v);
    return v & (~v + {{(NUM_CHN-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/mcontr_refresh_timer.sv
// Refresh tick generator with a saturating count of owed refreshes and the
// registered normal/urgent refresh requests derived from it.
module mcontr_refresh_timer
  import mcontr_pkg::*;
#(
  parameter int REFR_PERIOD = 1560,
  parameter int REFR_URGENT = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk0,
  input  logic              nrst,
  input  logic              en,
  input  logic              refr_start,
  output logic              rq_refresh,
  output logic              rq_refresh_urgent,
  output logic [PEND_W-1:0] refr_pending
);

  localparam int TW = (REFR_PERIOD > 1) ? $clog2(REFR_PERIOD) : 1;

  logic [TW-1:0]     timer;
  logic              tick;
  logic [PEND_W-1:0] pend_nxt;

  assign tick = en && (timer == TW'(REFR_PERIOD - 1));

  // A tick and a granted refresh on the same edge cancel out.
  always_comb begin
    pend_nxt = refr_pending;
    if (!en) begin
      pend_nxt = '0;
    end else if (tick && !refr_start) begin
      if (refr_pending != '1) pend_nxt = refr_pending + PEND_W'(1);
    end else if (refr_start && !tick) begin
      if (refr_pending != '0) pend_nxt = refr_pending - PEND_W'(1);
    end
  end

  always_ff @(negedge clk0) begin
    if (!nrst) begin
      timer             <= '0;
      refr_pending      <= '0;
      rq_refresh        <= 1'b0;
      rq_refresh_urgent <= 1'b0;
    end else begin
      timer             <= (!en || tick) ? '0 : timer + TW'(1);
      refr_pending      <= pend_nxt;
      rq_refresh        <= (pend_nxt != '0);
      rq_refresh_urgent <= (32'(pend_nxt) >= REFR_URGENT);
    end
  end

endmodule

// File: rtl/mcontr_access_timer.sv
// Times each arbiter grant using its channel length and returns the early
// next pulse; also hosts the refresh request generator.
module mcontr_access_timer
  import mcontr_pkg::*;
#(
  parameter int NEXT_AHEAD  = 7,
  parameter int LEN_W       = 8,
  parameter int REFR_PERIOD = 1560,
  parameter int REFR_URGENT = 4,
  parameter int PEND_W      = 3
) (
  input  logic                     clk0,
  input  logic                     nrst,
  input  logic                     en,
  input  logic [NUM_CHN-1:0]       start,
  input  logic [NUM_CHN*LEN_W-1:0] chn_len,
  output logic                     next,
  output logic                     active,
  output logic [NUM_CHN-1:0]       cur_chn,
  output logic                     rq_refresh,
  output logic                     rq_refresh_urgent,
  output logic [PEND_W-1:0]        refr_pending,
  output logic                     err_overlap
);

  // Handshake: start is a one-cycle one-hot grant accepted only in IDLE; next
  // pulses once per access, NEXT_AHEAD cycles before the first idle cycle, so
  // the arbiter can present the following grant exactly in that idle cycle.
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(NEXT_AHEAD + 1);

  acc_state_e         state, state_nxt;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [NUM_CHN-1:0] sel, cur_nxt;
  logic [LEN_W-1:0]   len_sel, len_eff;
  logic               multi, err_nxt, next_nxt;

  assign sel    = lowest_onehot(start);
  assign multi  = (start & (start - NUM_CHN'(1))) != '0;
  assign active = (state == ST_RUN);

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      if (sel[i]) len_sel = len_sel | chn_len[i*LEN_W +: LEN_W];
    end
  end

  assign len_eff = (len_sel < MIN_LEN) ? MIN_LEN : len_sel;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur_chn;
    err_nxt   = err_overlap;
    case (state)
      ST_IDLE: begin
        if (start != '0) begin
          state_nxt = ST_RUN;
          cnt_nxt   = len_eff - LEN_W'(1);
          cur_nxt   = sel;
          if (multi) err_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (start != '0) err_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          cur_nxt   = '0;
        end else begin
          cnt_nxt = cnt - LEN_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    next_nxt = (state_nxt == ST_RUN) && (cnt_nxt == LEN_W'(NEXT_AHEAD));
  end

  always_ff @(negedge clk0) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur_chn     <= '0;
      next        <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cur_chn     <= cur_nxt;
      next        <= next_nxt;
      err_overlap <= err_nxt;
    end
  end

  mcontr_refresh_timer #(
    .REFR_PERIOD (REFR_PERIOD),
    .REFR_URGENT (REFR_URGENT),
    .PEND_W      (PEND_W)
  ) u_refresh (
    .clk0              (clk0),
    .nrst              (nrst),
    .en                (en),
    .refr_start        (start[REFR_CHN]),
    .rq_refresh        (rq_refresh),
    .rq_refresh_urgent (rq_refresh_urgent),
    .refr_pending      (refr_pending)
  );

endmodule

// File: tb/tb_mcontr_access_timer.sv
// Directed and randomized bench for mcontr_access_timer against an
// interval-based reference model (access windows and tick counts).
module tb_mcontr_access_timer;

  localparam int NA = 7;
  localparam int LW = 8;
  localparam int RP = 20;
  localparam int RU = 4;
  localparam int PW = 3;

  // clock / reset
  logic clk0 = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  logic [8:0] start = '0;
  logic [9*LW-1:0] chn_len = '0;
  logic next, active, rq_refresh, rq_refresh_urgent, err_overlap;
  logic [8:0] cur_chn;
  logic [PW-1:0] refr_pending;

  always #5 clk0 = ~clk0;

  mcontr_access_timer #(
    .NEXT_AHEAD (NA), .LEN_W (LW), .REFR_PERIOD (RP),
    .REFR_URGENT (RU), .PEND_W (PW)
  ) dut (
    .clk0 (clk0), .nrst (nrst), .en (en), .start (start), .chn_len (chn_len),
    .next (next), .active (active), .cur_chn (cur_chn),
    .rq_refresh (rq_refresh), .rq_refresh_urgent (rq_refresh_urgent),
    .refr_pending (refr_pending), .err_overlap (err_overlap)
  );

  int n_assert = 0;
  int n_fail = 0;

  // reference model: access = window [acc_s, acc_s+acc_len) in edge numbers
  int edge_n = 0;
  bit acc_valid = 0;
  int acc_s = 0;
  int acc_len = 0;
  logic [8:0] acc_chn = '0;
  bit m_err = 0;
  int m_pend = 0;
  int m_tcnt = 0;

  function automatic bit m_active(int e);
    return acc_valid && (e >= acc_s) && (e < acc_s + acc_len);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one active edge, model update, then compare on the opposite edge
  task automatic cycle();
    bit busy, tick, s8, act;
    int idx, l;
    @(negedge clk0);
    edge_n++;
    if (!nrst) begin
      acc_valid = 0; m_err = 0; m_pend = 0; m_tcnt = 0;
    end else begin
      busy = m_active(edge_n - 1);
      if (start != '0) begin
        if (busy || $countones(start) > 1) m_err = 1;
        if (!busy) begin
          idx = 0;
          for (int i = 8; i >= 0; i--) if (start[i]) idx = i;
          l = int'(chn_len[idx*LW +: LW]);
          acc_valid = 1;
          acc_s = edge_n;
          acc_len = (l < NA + 1) ? NA + 1 : l;
          acc_chn = 9'(1) << idx;
        end
      end
      if (!en) begin
        m_tcnt = 0; m_pend = 0;
      end else begin
        m_tcnt++;
        tick = (m_tcnt % RP) == 0;
        s8 = start[8];
        if (tick && !s8 && m_pend < (1 << PW) - 1) m_pend++;
        else if (s8 && !tick && m_pend > 0) m_pend--;
      end
    end
    @(posedge clk0);
    act = m_active(edge_n);
    check("active", active, act);
    check("next", next, act && (edge_n == acc_s + acc_len - 1 - NA));
    check("cur_chn", cur_chn, act ? acc_chn : 9'h0);
    check("err_overlap", err_overlap, m_err);
    check("refr_pending", refr_pending, m_pend);
    check("rq_refresh", rq_refresh, m_pend != 0);
    check("rq_refresh_urgent", rq_refresh_urgent, m_pend >= RU);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start(input logic [8:0] v);
    start = v;
    cycle();
    start = '0;
  endtask

  int n_next;

  initial begin
    // reset
    nrst = 1'b0;
    run(2);
    nrst = 1'b1;
    run(2);

    // channel 0, length 16
    chn_len[0*LW +: LW] = 8'd16;
    pulse_start(9'h001);
    run(20);

    // channel 1, length 3 clamped to 8
    chn_len[1*LW +: LW] = 8'd3;
    pulse_start(9'h002);
    run(10);

    // multi-hot start, then a start during the access
    chn_len[2*LW +: LW] = 8'd10;
    pulse_start(9'h00C);
    check("multi_hot_cur", cur_chn, 9'h004);
    run(3);
    pulse_start(9'h010);
    check("overlap_err", err_overlap, 1'b1);
    run(10);

    // refresh accumulation
    en = 1'b1;
    run(80);
    check("pend_80", refr_pending, 4);
    check("urgent_80", rq_refresh_urgent, 1'b1);
    chn_len[8*LW +: LW] = 8'd0;
    pulse_start(9'h100);
    check("pend_after_refr", refr_pending, 3);
    check("urgent_dropped", rq_refresh_urgent, 1'b0);
    run(8);
    pulse_start(9'h100);
    run(8);
    while ((m_tcnt % RP) != RP - 1) cycle();
    pulse_start(9'h100);
    check("pend_tick_and_refr", refr_pending, 2);
    run(200);
    check("pend_saturated", refr_pending, 7);

    // reset in the middle of an access
    chn_len[3*LW +: LW] = 8'd20;
    pulse_start(9'h008);
    run(13);
    nrst = 1'b0;
    cycle();
    nrst = 1'b1;
    check("rst_active", active, 1'b0);
    check("rst_pend", refr_pending, 0);
    check("rst_err", err_overlap, 1'b0);
    n_next = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (next) n_next++;
    end
    check("no_next_after_abort", n_next, 0);

    // maximum length
    chn_len[4*LW +: LW] = 8'd255;
    pulse_start(9'h010);
    run(260);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      nrst = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      start = '0;
      if ($urandom_range(0, 9) == 0) begin
        for (int c = 0; c < 9; c++) chn_len[c*LW +: LW] = LW'($urandom_range(0, 30));
        if ($urandom_range(0, 9) < 7) start = 9'(1) << $urandom_range(0, 8);
        else start = 9'($urandom_range(1, 511));
      end
      cycle();
    end
    nrst = 1'b1;
    start = '0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
